// File: rtl/dualshock_spi_responder_pkg.sv
// Shared DualShock protocol constants, FSM state type and response-byte table.
package dualshock_pkg;

  localparam logic [7:0] CMD_START      = 8'h01;
  localparam logic [7:0] CMD_POLL       = 8'h42;
  localparam logic [7:0] PAD_ID_DIGITAL = 8'h41;
  localparam logic [7:0] DATA_MARK      = 8'h5A;
  localparam logic [7:0] IDLE_BYTE      = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    ID,
    DATA,
    TAIL,
    IGNORE
  } ds_state_t;

  // Pad response for a given byte position of a digital-mode poll.
  function automatic logic [7:0] response_byte(input logic [2:0]  idx,
                                               input logic [15:0] snap,
                                               input logic [7:0]  pad_id);
    logic [7:0] r;
    case (idx)
      3'd0:    r = IDLE_BYTE;
      3'd1:    r = pad_id;
      3'd2:    r = DATA_MARK;
      3'd3:    r = ~snap[7:0];
      3'd4:    r = ~snap[15:8];
      default: r = IDLE_BYTE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dualshock_spi_responder_if.sv
// DualShock SPI bus between the controller (master) and the pad (slave).
interface dualshock_spi_responder_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic spi_ack_n;

  modport master (
    output spi_clk,
    output spi_cs,
    output spi_mosi,
    input  spi_miso,
    input  spi_ack_n
  );

  modport slave (
    input  spi_clk,
    input  spi_cs,
    input  spi_mosi,
    output spi_miso,
    output spi_ack_n
  );
endinterface

// File: rtl/dualshock_spi_responder_sync.sv
// Multi-stage synchronizer for an asynchronous input, with rise/fall pulses.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Chain and edge history are left unreset so they keep tracking the pin
  // through reset; no spurious edge appears when reset releases.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], din};
    prev_q <= sync_q[STAGES-1];
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/dualshock_spi_responder.sv
// Pad-side DualShock 2 responder: answers digital-mode polls with a button snapshot.
module dualshock_spi_responder
  import dualshock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_CYCLES  = 32,  // >= 1
  parameter int unsigned ACK_DELAY   = 16,  // >= 1
  parameter logic [7:0]  PAD_ID      = PAD_ID_DIGITAL
) (
  input  logic                      clk,
  input  logic                      reset,
  dualshock_spi_responder_if.slave  spi,
  input  logic [15:0]               buttons,
  output logic                      poll_done,
  output logic                      cmd_error
);
  localparam int unsigned DLY_W = (ACK_DELAY  > 1) ? $clog2(ACK_DELAY)  : 1;
  localparam int unsigned CNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ACK_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_CYCLES - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall, cs_level;
  logic mosi_level;
  logic unused_sclk_level, unused_mosi_rise, unused_mosi_fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .din(spi.spi_clk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .din(spi.spi_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .din(spi.spi_mosi),
    .level(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  ds_state_t         state;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_idx;
  logic [7:0]        rx_shift;
  logic [15:0]       snapshot;
  logic [7:0]        resp_q;
  logic              miso_q;
  logic              ack_n_q;
  logic              ack_wait;
  logic [DLY_W-1:0]  ack_dly;
  logic [CNT_W-1:0]  ack_cnt;
  logic              poll_done_q;
  logic              cmd_error_q;

  logic [7:0]        rx_byte;
  logic [2:0]        idx_next;
  ds_state_t         bnd_state;
  logic              bnd_ack, bnd_err, bnd_done;
  logic [7:0]        bnd_resp;

  // Decisions taken when the current byte completes on this clk_rise.
  always_comb begin
    rx_byte   = {mosi_level, rx_shift[7:1]};
    idx_next  = (byte_idx == 3'd7) ? 3'd7 : byte_idx + 3'd1;
    bnd_state = state;
    bnd_ack   = 1'b0;
    bnd_err   = 1'b0;
    bnd_done  = 1'b0;
    case (state)
      HEADER: begin
        if (rx_byte == CMD_START) begin
          bnd_state = ID;
          bnd_ack   = 1'b1;
        end else begin
          bnd_state = IGNORE;
          bnd_err   = 1'b1;
        end
      end
      ID: begin
        if (rx_byte == CMD_POLL) begin
          bnd_state = DATA;
          bnd_ack   = 1'b1;
        end else begin
          bnd_state = IGNORE;
          bnd_err   = 1'b1;
        end
      end
      DATA: begin
        if (byte_idx == 3'd4) begin
          bnd_state = TAIL;
          bnd_done  = 1'b1;
        end else begin
          bnd_ack   = 1'b1;
        end
      end
      default: ;
    endcase
    bnd_resp = (bnd_state inside {HEADER, ID, DATA})
             ? response_byte(idx_next, snapshot, PAD_ID) : IDLE_BYTE;
  end

  // Protocol FSM, bit/byte framing, response shifting and ACK timing.
  always_ff @(posedge clk) begin
    poll_done_q <= 1'b0;
    cmd_error_q <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_idx <= '0;
      rx_shift <= '0;
      snapshot <= '0;
      resp_q   <= '1;
      miso_q   <= 1'b1;
      ack_n_q  <= 1'b1;
      ack_wait <= 1'b0;
      ack_dly  <= '0;
      ack_cnt  <= '0;
    end else begin
      if (ack_wait) begin
        if (ack_dly == '0) begin
          ack_wait <= 1'b0;
          ack_n_q  <= 1'b0;
          ack_cnt  <= CNT_LOAD;
        end else begin
          ack_dly <= ack_dly - 1'b1;
        end
      end else if (!ack_n_q) begin
        if (ack_cnt == '0) ack_n_q <= 1'b1;
        else               ack_cnt <= ack_cnt - 1'b1;
      end

      if (cs_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        byte_idx <= '0;
        resp_q   <= '1;
        miso_q   <= 1'b1;
        ack_wait <= 1'b0;
        ack_n_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= HEADER;
              snapshot <= buttons;
              bit_cnt  <= '0;
              byte_idx <= '0;
              resp_q   <= IDLE_BYTE;
              miso_q   <= IDLE_BYTE[0];
            end else if (!cs_level) begin
              // Chip select already low out of reset: a poll we never saw start.
              state <= IGNORE;
            end
          end
          default: begin
            if (sclk_rise) begin
              rx_shift <= rx_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_idx    <= idx_next;
                state       <= bnd_state;
                cmd_error_q <= bnd_err;
                poll_done_q <= bnd_done;
                resp_q      <= bnd_resp;
                miso_q      <= bnd_resp[0];
                if (bnd_ack) begin
                  ack_wait <= 1'b1;
                  ack_dly  <= DLY_LOAD;
                end
              end
            end else if (sclk_fall) begin
              // Indexing by bits-sampled makes the fall after a byte boundary
              // re-present bit 0 of the newly loaded byte instead of skipping it.
              miso_q <= resp_q[bit_cnt];
            end
          end
        endcase
      end
    end
  end

  assign spi.spi_miso  = miso_q;
  assign spi.spi_ack_n = ack_n_q;
  assign poll_done     = poll_done_q;
  assign cmd_error     = cmd_error_q;
endmodule
